jtbubl_objdraw: RTL and testbench
=================================

// Module: jtbubl_objdraw
// PURPOSE
//  Parametrised object/tile line drawer: takes one draw request (code, palette, flips, x, row),
//  fetches NTILES consecutive 8-pixel ROM words from SDRAM, decodes the 4bpp planar data and
//  writes up to NTILES*8 pixels into the object line buffer. Sits between the VRAM scan logic and
//  the line buffer. Adds multi-tile objects, a configurable transparent pen and abort over the
//  fixed two-half drawer.
// PARAMETERS
//  CW      10  code width; rom_addr width is CW+4
//  PW      4   palette width; buf_din width is PW+4
//  HW      9   line buffer address width
//  NTILES  2   8-pixel tiles per request, 1..8
//  INVERT  1   1: pen = ~decoded bits before compare/write
//  TRANSP  4'hF pen value (after INVERT) that is skipped (no write, address still advances)
// PORTS
//  clk       in   1      system clock
//  rst       in   1      asynchronous reset, active high
//  abort     in   1      synchronous cancel (blanking); returns to IDLE
//  draw      in   1      request strobe, accepted only when busy==0
//  busy      out  1      high from accept cycle+1 until last pixel written
//  code      in   CW     first tile code
//  pal       in   PW     palette
//  hflip     in   1      horizontal flip
//  vflip     in   1      vertical flip
//  hpos      in   HW     leftmost pixel x
//  ysub      in   3      row inside tile
//  rom_addr  out  CW+4   {tile_code, ysub^{3{vflip}}, 1'b0}
//  rom_cs    out  1      ROM request
//  rom_ok    in   1      ROM data valid
//  rom_data  in   32     8 pixels, 4 planes
//  buf_addr  out  HW     line buffer address
//  buf_we    out  1      line buffer write enable
//  buf_din   out  PW+4   {pal, pen}
// BEHAVIOUR
//  Reset: IDLE; busy, rom_cs, buf_we = 0; rom_addr, buf_addr, buf_din = 0.
//  Accept: draw && !busy && !abort latches all request inputs; tile index k=0; buf_addr<=hpos.
//  Tile code for step k: code+k (no flip) or code+NTILES-1-k (hflip); CW-bit wrap-around.
//  States: IDLE -> FETCH -> DRAW -> (FETCH if k<NTILES-1 else IDLE).
//  FETCH: rom_cs=1, rom_addr stable. rom_ok ignored for the first 2 cycles of each FETCH (stale ok
//   guard); first rom_ok after that latches rom_data, rom_cs<=0, -> DRAW. No timeout.
//  Plane decode: plane p byte = {rom_data[16+4p+:4], rom_data[4p+:4]}; pixel i (i=0 leftmost)
//   bits = {pl0[i],pl1[i],pl2[i],pl3[i]}; hflip uses bit 7-i. pen = INVERT ? ~bits : bits.
//  DRAW: exactly 8 cycles, one pixel per cycle; buf_we = (pen!=TRANSP); buf_din={pal,pen};
//   buf_addr increments by 1 after every pixel (written or skipped), wraps at 2^HW.
//  Pixel address continuity: tile k pixel i lands at hpos+8k+i regardless of hflip.
//  Latency: min first write 3 cycles after accept+rom_ok; per tile = FETCH(>=3) + 8.
//  busy falls the cycle after the last DRAW pixel; a new draw is accepted on that same cycle.
//  abort (any state): next cycle IDLE, busy/rom_cs/buf_we=0; abort wins over draw in same cycle.
//  draw while busy: ignored, no queueing.
//  rom_ok in IDLE/DRAW: ignored.
//  Async rst mid-operation: all outputs to reset values immediately, no partial write completes.
// TESTING
//  1 code=0x012,pal=3,hpos=0x40,ysub=5,no flip, rom_data=0x0000_0000, rom_ok 3 cyc after cs
//    -> rom_addr=0x012A then 0x013A, 16 writes addr 0x40..0x4F, buf_din=0x3F? no: pen 0xF skipped, 0 writes
//  2 same, rom_data=0xFFFF_FFFF, INVERT=1 -> 16 writes, pen 0x0, buf_din=0x30, busy low after last
//  3 hflip=1,vflip=1,ysub=0,code=0x3FF, NTILES=2 -> rom_addr 0x0000E then 0x3FFE (wrap), pixel order reversed
//  4 rom_data=0x0000_0001 -> only pixel0 pen=~0b1000=0x7 written at hpos; hflip -> at hpos+7
//  5 abort asserted on DRAW cycle 4 -> busy=0,buf_we=0,rom_cs=0 next cycle; next draw accepted
//  6 rom_ok held high continuously -> data latched only on 3rd FETCH cycle; rst mid-FETCH -> rom_cs=0 at once

Source files
------------

// File: rtl/jtbubl_objdraw_if.sv
// Request, ROM and line-buffer signals of the object line drawer.
interface jtbubl_objdraw_if #(
    parameter int CW = 10,
    parameter int PW = 4,
    parameter int HW = 9
);
    logic            abort;
    logic            draw;
    logic            busy;
    logic [CW-1:0]   code;
    logic [PW-1:0]   pal;
    logic            hflip;
    logic            vflip;
    logic [HW-1:0]   hpos;
    logic [2:0]      ysub;
    logic [CW+3:0]   rom_addr;
    logic            rom_cs;
    logic            rom_ok;
    logic [31:0]     rom_data;
    logic [HW-1:0]   buf_addr;
    logic            buf_we;
    logic [PW+3:0]   buf_din;

    modport master (
        output abort, draw, code, pal, hflip, vflip, hpos, ysub, rom_ok, rom_data,
        input  busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din
    );

    modport slave (
        input  abort, draw, code, pal, hflip, vflip, hpos, ysub, rom_ok, rom_data,
        output busy, rom_addr, rom_cs, buf_addr, buf_we, buf_din
    );
endinterface

// File: rtl/jtbubl_objdraw.sv
// Object line drawer: fetches NTILES 4bpp planar ROM words per request and
// writes one pixel per cycle into the object line buffer.
module jtbubl_objdraw #(
    parameter int         CW     = 10,
    parameter int         PW     = 4,
    parameter int         HW     = 9,
    parameter int         NTILES = 2,
    parameter bit         INVERT = 1'b1,
    parameter logic [3:0] TRANSP = 4'hF
) (
    input logic             clk,
    input logic             rst,
    jtbubl_objdraw_if.slave bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAW} state_t;

    state_t        state, nxt;
    logic [1:0]    wcnt;
    logic [2:0]    px;
    logic [3:0]    k;
    logic [CW-1:0] code_r;
    logic [PW-1:0] pal_r;
    logic          hflip_r, vflip_r;
    logic [2:0]    ysub_r;
    logic [31:0]   data_r;
    logic [CW+3:0] rom_addr_r;
    logic [HW-1:0] buf_addr_r;
    logic          accept, fetch_done, last_tile;
    logic [2:0]    bi;
    logic [3:0]    bits, pen;

    // hflip walks the codes backwards so pixels still land left to right
    function automatic logic [CW+3:0] tile_addr(input logic [CW-1:0] c, input logic hf,
                                                input logic vf, input logic [2:0] ys,
                                                input logic [3:0] kk);
        logic [CW-1:0] t;
        t = hf ? c + CW'(NTILES - 1) - CW'(kk) : c + CW'(kk);
        return {t, ys ^ {3{vf}}, 1'b0};
    endfunction

    assign accept     = state == IDLE && bus.draw && !bus.abort;
    assign fetch_done = state == FETCH && wcnt == 2'd2 && bus.rom_ok;
    assign last_tile  = k == 4'(NTILES - 1);
    assign bus.rom_addr = rom_addr_r;
    assign bus.buf_addr = buf_addr_r;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= nxt;

    always_comb begin
        nxt         = state;
        bus.busy    = state != IDLE;
        bus.rom_cs  = state == FETCH;
        bus.buf_we  = 1'b0;
        bus.buf_din = '0;
        case (state)
            IDLE:  if (accept) nxt = FETCH;
            FETCH: if (fetch_done) nxt = DRAW;
            DRAW: begin
                bus.buf_we  = pen != TRANSP;
                bus.buf_din = {pal_r, pen};
                if (px == 3'd7) nxt = last_tile ? IDLE : FETCH;
            end
            default: nxt = IDLE;
        endcase
        if (bus.abort) nxt = IDLE;
    end

    // plane p byte is {rom_data[16+4p+:4], rom_data[4p+:4]}; plane 0 is the pen MSB
    always_comb begin
        bits = '0;
        bi   = hflip_r ? ~px : px;
        for (int p = 0; p < 4; p++)
            bits[3-p] = bi[2] ? data_r[16 + 4*p + int'(bi[1:0])] : data_r[4*p + int'(bi[1:0])];
        pen = INVERT ? ~bits : bits;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt       <= '0;
            px         <= '0;
            k          <= '0;
            code_r     <= '0;
            pal_r      <= '0;
            hflip_r    <= 1'b0;
            vflip_r    <= 1'b0;
            ysub_r     <= '0;
            data_r     <= '0;
            rom_addr_r <= '0;
            buf_addr_r <= '0;
        end else if (accept) begin
            code_r     <= bus.code;
            pal_r      <= bus.pal;
            hflip_r    <= bus.hflip;
            vflip_r    <= bus.vflip;
            ysub_r     <= bus.ysub;
            k          <= '0;
            wcnt       <= '0;
            buf_addr_r <= bus.hpos;
            rom_addr_r <= tile_addr(bus.code, bus.hflip, bus.vflip, bus.ysub, 4'd0);
        end else if (state == FETCH) begin
            // the first two FETCH cycles may still see an ok meant for a previous request
            if (wcnt != 2'd2) wcnt <= wcnt + 2'd1;
            if (fetch_done) begin
                data_r <= bus.rom_data;
                px     <= '0;
            end
        end else if (state == DRAW) begin
            px         <= px + 3'd1;
            buf_addr_r <= buf_addr_r + HW'(1);
            if (px == 3'd7 && !last_tile) begin
                k          <= k + 4'd1;
                wcnt       <= '0;
                rom_addr_r <= tile_addr(code_r, hflip_r, vflip_r, ysub_r, k + 4'd1);
            end
        end
    end
endmodule

// File: tb/tb_jtbubl_objdraw.sv
// Directed and randomized checks of jtbubl_objdraw against a pixel-list reference model.
module tb_jtbubl_objdraw;
    localparam int NT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jtbubl_objdraw_if #(.CW(10), .PW(4), .HW(9)) bus ();

    jtbubl_objdraw #(.CW(10), .PW(4), .HW(9), .NTILES(NT), .INVERT(1'b1), .TRANSP(4'hF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          nchk = 0;
    int          nfail = 0;
    logic [31:0] td [NT];
    logic [16:0] capq[$];
    logic [16:0] expq[$];
    logic        cap_en = 1'b0;

    always @(negedge clk)
        if (cap_en && bus.buf_we === 1'b1) capq.push_back({bus.buf_addr, bus.buf_din});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [13:0] ref_addr(input logic [9:0] c, input logic hf, input logic vf,
                                             input logic [2:0] ys, input int k);
        int cc, t, row;
        cc  = int'(c);
        t   = hf ? (cc + NT - 1 - k) % 1024 : (cc + k) % 1024;
        row = vf ? 7 - int'(ys) : int'(ys);
        return 14'(t * 16 + row * 2);
    endfunction

    // expected writes for the first npix pixels, from td[] and the pen rules
    task automatic build_exp(input logic [3:0] pl, input logic hf, input logic [8:0] hp, input int npix);
        int k, i, col, bits, pen, plane;
        expq.delete();
        for (int j = 0; j < npix; j++) begin
            k    = j / 8;
            i    = j % 8;
            col  = hf ? 7 - i : i;
            bits = 0;
            for (int p = 0; p < 4; p++) begin
                plane = int'((td[k] >> (16 + 4*p)) & 32'hF) * 16 + int'((td[k] >> (4*p)) & 32'hF);
                bits  = bits + (((plane >> col) & 1) << (3 - p));
            end
            pen = 15 - bits;
            if (pen != 15)
                expq.push_back(17'(((int'(hp) + 8*k + i) % 512) * 256 + int'(pl) * 16 + pen));
        end
    endtask

    task automatic cmp_writes(input string nm);
        cap_en = 1'b0;
        chk({nm, ".nwr"}, capq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < capq.size(); i++)
            chk({nm, ".wr"}, 32'(capq[i]), 32'(expq[i]));
    endtask

    task automatic set_req(input logic [9:0] c, input logic [3:0] pl, input logic hf, input logic vf,
                           input logic [8:0] hp, input logic [2:0] ys);
        bus.draw  = 1'b1;
        bus.code  = c;
        bus.pal   = pl;
        bus.hflip = hf;
        bus.vflip = vf;
        bus.hpos  = hp;
        bus.ysub  = ys;
    endtask

    // entered and left on a negedge; consecutive calls exercise same-cycle re-accept
    task automatic run_req(input logic [9:0] c, input logic [3:0] pl, input logic hf, input logic vf,
                           input logic [8:0] hp, input logic [2:0] ys, input int okdly, input string nm);
        int n, t, lim;
        build_exp(pl, hf, hp, NT * 8);
        capq.delete();
        cap_en = 1'b1;
        set_req(c, pl, hf, vf, hp, ys);
        @(negedge clk);
        bus.draw  = 1'b0;
        bus.code  = 10'($urandom);
        bus.pal   = 4'($urandom);
        bus.hflip = 1'($urandom);
        bus.vflip = 1'($urandom);
        bus.hpos  = 9'($urandom);
        bus.ysub  = 3'($urandom);
        chk({nm, ".busy"}, bus.busy, 1);
        lim = okdly > 2 ? okdly : 2;
        for (int k = 0; k < NT; k++) begin
            n = 0;
            while (bus.rom_cs !== 1'b1 && n < 40) begin
                bus.rom_ok = 1'($urandom);
                @(negedge clk);
                n++;
            end
            chk({nm, ".gap"}, n, k == 0 ? 0 : 8);
            chk({nm, ".raddr"}, bus.rom_addr, ref_addr(c, hf, vf, ys, k));
            t = 0;
            while (bus.rom_cs === 1'b1 && t < 40) begin
                bus.draw     = (k == 0);
                bus.rom_ok   = (t >= okdly);
                bus.rom_data = (t >= lim) ? td[k] : $urandom;
                @(negedge clk);
                t++;
            end
            bus.rom_ok   = 1'b0;
            bus.draw     = 1'b0;
            bus.rom_data = $urandom;
            chk({nm, ".fetch"}, t, lim + 1);
        end
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            bus.rom_ok = 1'($urandom);
            @(negedge clk);
            n++;
        end
        bus.rom_ok = 1'b0;
        chk({nm, ".tail"}, n, 8);
        cmp_writes(nm);
    endtask

    initial begin
        int n, t;
        bus.abort    = 1'b0;
        bus.draw     = 1'b0;
        bus.code     = '0;
        bus.pal      = '0;
        bus.hflip    = 1'b0;
        bus.vflip    = 1'b0;
        bus.hpos     = '0;
        bus.ysub     = '0;
        bus.rom_ok   = 1'b0;
        bus.rom_data = '0;
        rst          = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst.busy", bus.busy, 0);
        chk("rst.cs", bus.rom_cs, 0);
        chk("rst.we", bus.buf_we, 0);
        chk("rst.raddr", bus.rom_addr, 0);
        chk("rst.baddr", bus.buf_addr, 0);
        chk("rst.din", bus.buf_din, 0);
        rst = 1'b0;
        @(negedge clk);

        td[0] = 32'h0; td[1] = 32'h0;
        run_req(10'h012, 4'h3, 1'b0, 1'b0, 9'h040, 3'd5, 3, "t1");
        chk("t1.raddr1", bus.rom_addr, 14'h013A);
        td[0] = 32'hFFFF_FFFF; td[1] = 32'hFFFF_FFFF;
        run_req(10'h012, 4'h3, 1'b0, 1'b0, 9'h040, 3'd5, 3, "t2");
        chk("t2.first", capq.size() > 0 ? 32'(capq[0]) : 32'hDEAD, {15'd0, 9'h040, 8'h30});
        chk("t2.last", capq.size() > 15 ? 32'(capq[15]) : 32'hDEAD, {15'd0, 9'h04F, 8'h30});
        td[0] = $urandom; td[1] = $urandom;
        run_req(10'h3FF, 4'h9, 1'b1, 1'b1, 9'h0A0, 3'd0, 2, "t3");
        chk("t3.raddr1", bus.rom_addr, 14'h3FFE);
        td[0] = 32'h1; td[1] = 32'h0;
        run_req(10'h155, 4'h5, 1'b0, 1'b0, 9'h080, 3'd2, 2, "t4a");
        chk("t4a.pix", capq.size() > 0 ? 32'(capq[0]) : 32'hDEAD, {15'd0, 9'h080, 4'h5, 4'h7});
        run_req(10'h155, 4'h5, 1'b1, 1'b0, 9'h080, 3'd2, 2, "t4b");
        chk("t4b.pix", capq.size() > 0 ? 32'(capq[0]) : 32'hDEAD, {15'd0, 9'h087, 4'h5, 4'h7});
        td[0] = $urandom; td[1] = $urandom;
        run_req(10'($urandom), 4'($urandom), 1'b0, 1'b1, 9'h1FC, 3'($urandom), 0, "wrap");
        run_req(10'($urandom), 4'($urandom), 1'b1, 1'b0, 9'h1FA, 3'($urandom), 0, "wraph");

        for (int r = 0; r < 20; r++) begin
            td[0] = $urandom; td[1] = $urandom;
            run_req(10'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 9'($urandom),
                    3'($urandom), int'($urandom_range(0, 5)), "rnd");
        end

        // abort in the fifth DRAW cycle of the first tile
        td[0] = 32'hFFFF_FFFF; td[1] = $urandom;
        build_exp(4'hA, 1'b0, 9'h010, 5);
        capq.delete();
        cap_en = 1'b1;
        set_req(10'h020, 4'hA, 1'b0, 1'b0, 9'h010, 3'd1);
        @(negedge clk);
        bus.draw = 1'b0;
        t = 0;
        while (bus.rom_cs === 1'b1 && t < 40) begin
            bus.rom_ok   = 1'b1;
            bus.rom_data = (t >= 2) ? td[0] : $urandom;
            @(negedge clk);
            t++;
        end
        bus.rom_ok = 1'b0;
        chk("abort.fetch", t, 3);
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        bus.draw  = 1'b1;
        @(negedge clk);
        chk("abort.busy", bus.busy, 0);
        chk("abort.we", bus.buf_we, 0);
        chk("abort.cs", bus.rom_cs, 0);
        bus.abort = 1'b0;
        bus.draw  = 1'b0;
        cmp_writes("abort");
        td[0] = $urandom; td[1] = $urandom;
        run_req(10'h0F0, 4'h2, 1'b0, 1'b0, 9'h100, 3'd3, 1, "postab");

        // async reset while fetching
        set_req(10'h030, 4'h1, 1'b0, 1'b0, 9'h050, 3'd4);
        @(negedge clk);
        bus.draw = 1'b0;
        @(negedge clk);
        chk("rstf.cs_before", bus.rom_cs, 1);
        rst = 1'b1;
        #1;
        chk("rstf.cs", bus.rom_cs, 0);
        chk("rstf.busy", bus.busy, 0);
        chk("rstf.raddr", bus.rom_addr, 0);
        chk("rstf.baddr", bus.buf_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // async reset while writing pixels
        set_req(10'h031, 4'h6, 1'b0, 1'b0, 9'h060, 3'd4);
        @(negedge clk);
        bus.draw = 1'b0;
        n = 0;
        while (bus.rom_cs === 1'b1 && n < 40) begin
            bus.rom_ok   = 1'b1;
            bus.rom_data = 32'hFFFF_FFFF;
            @(negedge clk);
            n++;
        end
        bus.rom_ok = 1'b0;
        @(negedge clk);
        chk("rstd.we_before", bus.buf_we, 1);
        rst = 1'b1;
        #1;
        chk("rstd.we", bus.buf_we, 0);
        chk("rstd.din", bus.buf_din, 0);
        chk("rstd.busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstd.idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, compared %0d", nchk);
        $fatal(1, "timeout");
    end
endmodule
